// File: rtl/aes_dev_pkg.sv
// Shared types and default sizes for the AES256 device controller.
// Optional build macro used by the top: AES_DEV_STATS_EN.
package aes_dev_pkg;

    localparam int DATA_W_DEF    = 128;
    localparam int NUM_RKEYS_DEF = 15;

    typedef enum logic [1:0] {
        MODE_ENC    = 2'b00,
        MODE_DEC    = 2'b01,
        MODE_KEYGEN = 2'b10,
        MODE_RSVD   = 2'b11
    } modeT;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEED1,
        S_KGEN,
        S_RUN,
        S_OUT
    } stateT;

endpackage

// File: rtl/aes_dev_watchdog.sv
// Engine watchdog: start arms and begins counting, clear disarms,
// expire is raised TIMEOUT-1 cycles after the start cycle.
module aes_dev_watchdog #(
    parameter int TIMEOUT = 64,
    parameter int TO_W    = 7
) (
    input  logic clk,
    input  logic resetn,
    input  logic start,
    input  logic clear,
    output logic expire
);

    localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT - 1);

    logic            armed;
    logic [TO_W-1:0] cnt;

    assign expire = armed && (cnt == LAST);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            armed <= 1'b0;
            cnt   <= '0;
        end else if (start) begin
            // start cycle counts as cycle 0, so the next cycle reads 1
            armed <= 1'b1;
            cnt   <= TO_W'(1);
        end else if (clear) begin
            armed <= 1'b0;
            cnt   <= '0;
        end else if (armed && !expire) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/aes256_dev_ctrl.sv
// AES256 device sequencer: seed/keygen ROM fill, enc/dec jobs, held result stream.
// Define AES_DEV_STATS_EN to add blk_cnt/err_cnt statistics ports.
module aes256_dev_ctrl
    import aes_dev_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int NUM_RKEYS = NUM_RKEYS_DEF,
    parameter int RK_AW     = 4,
    parameter int TIMEOUT   = 64,
    parameter int TO_W      = 7
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_data,
    input  logic [1:0]          in_mode,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_err,
    output logic                key_ready,
    output logic                eng_start,
    output logic                eng_dec,
    output logic [DATA_W-1:0]   eng_din,
    input  logic                eng_done,
    input  logic [DATA_W-1:0]   eng_dout,
    output logic                kg_start,
    output logic [2*DATA_W-1:0] kg_seed,
    input  logic                kg_valid,
    input  logic [DATA_W-1:0]   kg_key,
    output logic                rk_we,
    output logic [RK_AW-1:0]    rk_addr,
    output logic [DATA_W-1:0]   rk_wdata
`ifdef AES_DEV_STATS_EN
    ,
    output logic [31:0]         blk_cnt,
    output logic [15:0]         err_cnt
`endif
);

    localparam logic [RK_AW-1:0] LAST_RK = RK_AW'(NUM_RKEYS - 1);

    stateT             state;
    logic [RK_AW-1:0]  cnt;
    logic              inRdy, outValid, outErr, keyReady, engStart, engDec, kgStart;
    logic [DATA_W-1:0] outData, engDin, seedLo, seedHi;
    logic              wdExpire, inFire, kgWrite;

    assign inFire  = in_valid && inRdy;
    assign kgWrite = (state == S_KGEN) && kg_valid;

    aes_dev_watchdog #(.TIMEOUT(TIMEOUT), .TO_W(TO_W)) uWd (
        .clk    (clk),
        .resetn (resetn),
        .start  (engStart),
        .clear  (state != S_RUN),
        .expire (wdExpire)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= S_IDLE;
            cnt      <= '0;
            inRdy    <= 1'b0;
            outValid <= 1'b0;
            outErr   <= 1'b0;
            outData  <= '0;
            keyReady <= 1'b0;
            engStart <= 1'b0;
            engDec   <= 1'b0;
            engDin   <= '0;
            kgStart  <= 1'b0;
            seedLo   <= '0;
            seedHi   <= '0;
        end else begin
            engStart <= 1'b0;
            kgStart  <= 1'b0;
            case (state)
                S_IDLE: begin
                    inRdy <= 1'b1;
                    if (inFire) begin
                        if (in_mode == MODE_KEYGEN) begin
                            seedLo   <= in_data;
                            keyReady <= 1'b0;
                            state    <= S_SEED1;
                        end else if (in_mode != MODE_RSVD && keyReady) begin
                            engDin   <= in_data;
                            engDec   <= in_mode[0];
                            engStart <= 1'b1;
                            inRdy    <= 1'b0;
                            state    <= S_RUN;
                        end else begin
                            outValid <= 1'b1;
                            outErr   <= 1'b1;
                            outData  <= '0;
                            inRdy    <= 1'b0;
                            state    <= S_OUT;
                        end
                    end
                end
                S_SEED1: begin
                    if (inFire) begin
                        inRdy <= 1'b0;
                        if (in_mode == MODE_KEYGEN) begin
                            seedHi  <= in_data;
                            cnt     <= '0;
                            kgStart <= 1'b1;
                            state   <= S_KGEN;
                        end else begin
                            outValid <= 1'b1;
                            outErr   <= 1'b1;
                            outData  <= '0;
                            state    <= S_OUT;
                        end
                    end
                end
                S_KGEN: begin
                    if (kg_valid) begin
                        if (cnt == LAST_RK) begin
                            keyReady <= 1'b1;
                            inRdy    <= 1'b1;
                            cnt      <= '0;
                            state    <= S_IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    // a done on the expiry cycle still counts as in time
                    if (eng_done) begin
                        outValid <= 1'b1;
                        outErr   <= 1'b0;
                        outData  <= eng_dout;
                        state    <= S_OUT;
                    end else if (wdExpire) begin
                        outValid <= 1'b1;
                        outErr   <= 1'b1;
                        outData  <= '0;
                        state    <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        outValid <= 1'b0;
                        outErr   <= 1'b0;
                        outData  <= '0;
                        inRdy    <= 1'b1;
                        state    <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef AES_DEV_STATS_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            blk_cnt <= '0;
            err_cnt <= '0;
        end else if (outValid && out_ready) begin
            if (outErr) err_cnt <= err_cnt + 1'b1;
            else        blk_cnt <= blk_cnt + 1'b1;
        end
    end
`endif

    assign in_ready  = inRdy;
    assign out_valid = outValid;
    assign out_data  = outData;
    assign out_err   = outErr;
    assign key_ready = keyReady;
    assign eng_start = engStart;
    assign eng_dec   = engDec;
    assign eng_din   = engDin;
    assign kg_start  = kgStart;
    assign kg_seed   = {seedHi, seedLo};
    assign rk_we     = kgWrite;
    assign rk_addr   = cnt;
    assign rk_wdata  = kgWrite ? kg_key : '0;

endmodule

// File: tb/tb_aes256_dev_ctrl.sv
// Directed bench for aes256_dev_ctrl with a transaction-level reference model
// and a bench-side engine/keygen responder.
module tb_aes256_dev_ctrl;

    localparam int DATA_W    = 128;
    localparam int NUM_RKEYS = 15;
    localparam int RK_AW     = 4;
    localparam int TIMEOUT   = 64;
    localparam int TO_W      = 7;

    localparam logic [DATA_W-1:0] PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [DATA_W-1:0] CT   = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [DATA_W-1:0] SD0  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [DATA_W-1:0] SD1  = 128'h101112131415161718191a1b1c1d1e1f;

    logic                clk = 1'b0;
    logic                resetn = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [DATA_W-1:0]   in_data = '0;
    logic [1:0]          in_mode = '0;
    logic                out_valid;
    logic                out_ready = 1'b1;
    logic [DATA_W-1:0]   out_data;
    logic                out_err, key_ready, eng_start, eng_dec, kg_start, rk_we;
    logic [DATA_W-1:0]   eng_din;
    logic                eng_done = 1'b0;
    logic [DATA_W-1:0]   eng_dout = '0;
    logic [2*DATA_W-1:0] kg_seed;
    logic                kg_valid = 1'b0;
    logic [DATA_W-1:0]   kg_key = '0;
    logic [RK_AW-1:0]    rk_addr;
    logic [DATA_W-1:0]   rk_wdata;

    aes256_dev_ctrl #(
        .DATA_W(DATA_W), .NUM_RKEYS(NUM_RKEYS), .RK_AW(RK_AW), .TIMEOUT(TIMEOUT), .TO_W(TO_W)
    ) dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err),
        .key_ready(key_ready),
        .eng_start(eng_start), .eng_dec(eng_dec), .eng_din(eng_din),
        .eng_done(eng_done), .eng_dout(eng_dout),
        .kg_start(kg_start), .kg_seed(kg_seed), .kg_valid(kg_valid), .kg_key(kg_key),
        .rk_we(rk_we), .rk_addr(rk_addr), .rk_wdata(rk_wdata)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nFail = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] rkey(input int k);
        return {4{32'hC0DE0000 | 32'(k)}};
    endfunction

    // ---------------- reference model ----------------
    typedef enum {P_IDLE, P_SEED1, P_KGEN, P_BUSY} phaseT;
    typedef struct {
        bit                err;
        logic [DATA_W-1:0] data;
    } beatT;

    phaseT             mPhase = P_IDLE;
    bit                mInReady, mKeyReady, mStartDue, mKgDue, mDec;
    logic [DATA_W-1:0] mBlock, mSeedLo, mSeedHi;
    int                mKeyCnt;
    beatT              expQ[$];
    beatT              nb;

    int                engLat = 14;
    logic [DATA_W-1:0] engResult = '0;
    int                cyc = 0, startCyc = 0, outRiseCyc = 0;
    bit                prevOv, lastDec;
    logic [255:0]      lastSeed = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // The engine answers engLat cycles after eng_start (0 = never).
    initial forever begin
        @(negedge clk);
        if (eng_start && engLat > 0) begin
            repeat (engLat) @(posedge clk);
            #1 eng_done = 1'b1; eng_dout = engResult;
            @(posedge clk);
            #1 eng_done = 1'b0; eng_dout = '0;
        end
    end

    // Compare DUT against the model, then advance the model by this cycle's events.
    always @(negedge clk) begin
        if (!resetn) begin
            mPhase = P_IDLE; mInReady = 0; mKeyReady = 0; mStartDue = 0; mKgDue = 0;
            mKeyCnt = 0; prevOv = 0; expQ.delete();
        end else begin
            chk("in_ready", in_ready, mInReady);
            chk("key_ready", key_ready, mKeyReady);
            chk("eng_start", eng_start, mStartDue);
            chk("kg_start", kg_start, mKgDue);
            chk("rk_we", rk_we, mPhase == P_KGEN && kg_valid);
            if (mPhase == P_KGEN && kg_valid) begin
                chk("rk_addr", rk_addr, mKeyCnt);
                chk("rk_wdata", rk_wdata, rkey(mKeyCnt));
            end
            if (eng_start) begin
                chk("eng_din", eng_din, mBlock);
                chk("eng_dec", eng_dec, mDec);
                startCyc = cyc; lastDec = eng_dec;
            end
            if (kg_start) begin
                chk("kg_seed", kg_seed, {mSeedHi, mSeedLo});
                lastSeed = kg_seed;
            end
            if (mPhase != P_BUSY) chk("out_valid idle", out_valid, 0);
            else if (out_valid) begin
                chk("beat expected", expQ.size() != 0, 1);
                if (expQ.size() != 0) begin
                    chk("out_err", out_err, expQ[0].err);
                    chk("out_data", out_data, expQ[0].data);
                end
            end
            if (out_valid && !prevOv) outRiseCyc = cyc;
            prevOv = out_valid;

            mStartDue = 0; mKgDue = 0;
            if (mPhase == P_KGEN && kg_valid) begin
                mKeyCnt++;
                if (mKeyCnt == NUM_RKEYS) begin mKeyReady = 1; mPhase = P_IDLE; end
            end else if (mPhase == P_BUSY && out_valid && out_ready && expQ.size() != 0) begin
                void'(expQ.pop_front());
                mPhase = P_IDLE;
            end else if (in_valid && mInReady) begin
                nb.err = 1; nb.data = '0;
                if (in_mode == 2'b10) begin
                    if (mPhase == P_IDLE) begin
                        mSeedLo = in_data; mKeyReady = 0; mPhase = P_SEED1;
                    end else begin
                        mSeedHi = in_data; mKeyCnt = 0; mKgDue = 1; mPhase = P_KGEN;
                    end
                end else begin
                    if (mPhase == P_IDLE && in_mode != 2'b11 && mKeyReady) begin
                        mBlock = in_data; mDec = in_mode[0]; mStartDue = 1;
                        if (engLat > 0 && engLat < TIMEOUT) begin nb.err = 0; nb.data = engResult; end
                    end
                    expQ.push_back(nb);
                    mPhase = P_BUSY;
                end
            end
            mInReady = (mPhase == P_IDLE || mPhase == P_SEED1);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic sendBeat(input logic [1:0] mode, input logic [DATA_W-1:0] data);
        int n = 0;
        @(posedge clk); #1;
        in_valid = 1'b1; in_mode = mode; in_data = data;
        @(negedge clk);
        while (!in_ready && n < 200) begin @(negedge clk); n++; end
        chk("in handshake", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_mode = '0; in_data = '0;
    endtask

    task automatic waitBeat(output bit err, output logic [DATA_W-1:0] data);
        int n = 0;
        @(negedge clk);
        while (!out_valid && n < 300) begin @(negedge clk); n++; end
        chk("out beat arrives", out_valid, 1);
        err = out_err; data = out_data;
        @(posedge clk); #1;
    endtask

    task automatic kgPulse(input int k);
        @(posedge clk); #1 kg_valid = 1'b1; kg_key = rkey(k);
        @(posedge clk); #1 kg_valid = 1'b0; kg_key = '0;
    endtask

    task automatic loadKeys(input int n);
        for (int k = 0; k < n; k++) kgPulse(k);
    endtask

    task automatic chkAllZero(input string tag);
        chk({tag, " in_ready"}, in_ready, 0);
        chk({tag, " out_valid"}, out_valid, 0);
        chk({tag, " out_data"}, out_data, 0);
        chk({tag, " key_ready"}, key_ready, 0);
        chk({tag, " eng_din"}, eng_din, 0);
        chk({tag, " kg_seed"}, kg_seed, 0);
        chk({tag, " rk_we"}, rk_we, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit                e;
        logic [DATA_W-1:0] d, d0;
        int                n;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chkAllZero("reset");
        @(posedge clk); #1 resetn = 1'b1;

        // enc before keys
        engLat = 14; engResult = CT;
        sendBeat(2'b00, PT);
        waitBeat(e, d);
        chk("nokey err", e, 1);
        chk("nokey data", d, 0);

        // key load
        sendBeat(2'b10, SD0);
        sendBeat(2'b10, SD1);
        loadKeys(NUM_RKEYS);
        @(negedge clk);
        chk("key_ready after load", key_ready, 1);
        chk("seed literal", lastSeed, 256'h101112131415161718191a1b1c1d1e1f000102030405060708090a0b0c0d0e0f);
        kgPulse(NUM_RKEYS);

        // encrypt FIPS-197 C.3
        engLat = 14; engResult = CT;
        sendBeat(2'b00, PT);
        waitBeat(e, d);
        chk("enc data", d, 128'h8ea2b7ca516745bfeafc49904b496089);
        chk("enc err", e, 0);
        chk("enc latency", outRiseCyc - startCyc, 15);
        chk("enc dir", lastDec, 0);

        // decrypt
        engResult = PT;
        sendBeat(2'b01, CT);
        waitBeat(e, d);
        chk("dec data", d, PT);
        chk("dec dir", lastDec, 1);

        // backpressure
        out_ready = 1'b0; engLat = 3; engResult = 128'hdeadbeef;
        sendBeat(2'b00, PT);
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 100) begin @(negedge clk); n++; end
        d0 = out_data;
        repeat (10) @(negedge clk);
        chk("bp held valid", out_valid, 1);
        chk("bp held data", out_data, d0);
        chk("bp in_ready", in_ready, 0);
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        chk("bp release valid", out_valid, 1);
        @(negedge clk);
        chk("bp drop valid", out_valid, 0);
        chk("bp idle ready", in_ready, 1);

        // watchdog with a late done
        engLat = TIMEOUT + 6; engResult = CT;
        sendBeat(2'b00, PT);
        waitBeat(e, d);
        chk("wd err", e, 1);
        chk("wd data", d, 0);
        chk("wd delay", outRiseCyc - startCyc, TIMEOUT);
        repeat (20) @(posedge clk);

        // reserved mode
        sendBeat(2'b11, PT);
        waitBeat(e, d);
        chk("rsvd err", e, 1);

        // keygen beat then enc beat
        engLat = 14;
        sendBeat(2'b10, SD0);
        sendBeat(2'b00, PT);
        waitBeat(e, d);
        chk("abort err", e, 1);
        @(negedge clk);
        chk("abort key_ready", key_ready, 0);

        // reset during KGEN after 7 keys
        sendBeat(2'b10, SD0);
        sendBeat(2'b10, SD1);
        loadKeys(7);
        @(posedge clk); #1 resetn = 1'b0;
        @(negedge clk);
        chkAllZero("midreset");
        @(posedge clk); #1 resetn = 1'b1;
        sendBeat(2'b10, SD1);
        sendBeat(2'b10, SD0);
        loadKeys(NUM_RKEYS);
        @(negedge clk);
        chk("reload key_ready", key_ready, 1);
        engResult = CT;
        sendBeat(2'b00, PT);
        waitBeat(e, d);
        chk("reload enc data", d, CT);

        repeat (5) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
